// File: rtl/sample_word_recorder.sv
// Serial capture of CHANNELS bit-streams into WORD_W-bit words.
// Completed word vectors are queued in a small FIFO with overflow accounting.
module sample_word_recorder #(
    parameter int CHANNELS   = 1,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 0
) (
    input  logic                               clk,
    input  logic                               resetN,
    input  logic                               enable,
    input  logic                               clear,
    input  logic                               samplePulse,
    input  logic [CHANNELS-1:0]                dIn,
    output logic [CHANNELS*WORD_W-1:0]         outData,
    output logic                               outValid,
    input  logic                               outReady,
    output logic                               overflow,
    output logic [15:0]                        dropCount,
    output logic [$clog2(WORD_W+1)-1:0]        bitCount,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fillLevel
);

    localparam int BW = $clog2(WORD_W + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int VW = CHANNELS * WORD_W;

    logic          pulseQ;
    logic          strobe;
    logic          wordDone;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [VW-1:0] shQ;
    logic [VW-1:0] shNext;
    logic [VW-1:0] mem [FIFO_DEPTH];
    logic [PW:0]   wrPtr;
    logic [PW:0]   rdPtr;
    logic [PW:0]   count;

    assign strobe   = samplePulse & ~pulseQ & enable & ~clear;
    assign wordDone = strobe & (bitCount == BW'(WORD_W - 1));

    // Next shift value already contains the current bit, so the
    // completing strobe can push it without an extra cycle.
    always_comb begin
        shNext = shQ;
        for (int c = 0; c < CHANNELS; c++) begin
            if (MSB_FIRST != 0)
                shNext[c*WORD_W +: WORD_W] =
                    {shQ[c*WORD_W +: WORD_W-1], dIn[c]};
            else
                shNext[c*WORD_W +: WORD_W] =
                    {dIn[c], shQ[c*WORD_W+1 +: WORD_W-1]};
        end
    end

    assign count     = wrPtr - rdPtr;
    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign outValid  = (count != '0);
    assign pop       = outValid & outReady;
    assign push      = wordDone & (~full | pop);
    assign drop      = wordDone & full & ~pop;
    assign fillLevel = count;
    assign outData   = outValid ? mem[rdPtr[PW-1:0]] : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            pulseQ <= 1'b0;
        else
            pulseQ <= samplePulse;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shQ       <= '0;
            bitCount  <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            overflow  <= 1'b0;
            dropCount <= '0;
        end else if (clear) begin
            shQ       <= '0;
            bitCount  <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            overflow  <= 1'b0;
            dropCount <= '0;
        end else begin
            if (strobe) begin
                shQ      <= shNext;
                bitCount <= wordDone ? '0 : bitCount + 1'b1;
            end
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (dropCount != 16'hFFFF)
                    dropCount <= dropCount + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wrPtr[PW-1:0]] <= shNext;
        end
    end

endmodule

// File: doc/sample_word_recorder.md
# sample_word_recorder

Parametrised serial-capture unit for the channel datapath. It samples CHANNELS serial inputs on each rising edge of `samplePulse` and packs WORD_W bits per channel into a word, LSB-first or MSB-first. Completed word vectors are buffered in a FIFO_DEPTH-deep FIFO and drained through a valid/ready interface, with overflow accounting. It replaces fixed 32-bit, single-channel, no-backpressure recording in the channel unit.

## Interface
- `CHANNELS`, default 1: number of parallel serial inputs (1..8).
- `WORD_W`, default 32: bits per word (2..64).
- `FIFO_DEPTH`, default 4: word-vector FIFO entries (power of two, ≥2).
- `MSB_FIRST`, default 0: 0 = first sampled bit lands in bit 0; 1 = first sampled bit lands in bit WORD_W-1.

- `clk`  in  1  sole clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `enable`  in  1  sampling gate; strobes are ignored while low.
- `clear`  in  1  synchronous flush of partial word, FIFO, and counters.
- `samplePulse`  in  1  sample request, synchronous to `clk`; its rising edge samples `dIn`.
- `dIn`  in  CHANNELS  serial data, one bit per channel.
- `outData`  out  CHANNELS*WORD_W  FIFO head; channel c occupies bits [c*WORD_W +: WORD_W].
- `outValid`  out  1  FIFO non-empty.
- `outReady`  in  1  consumer accepts the head word.
- `overflow`  out  1  sticky; set when a completed word is dropped.
- `dropCount`  out  16  dropped words, saturating at 0xFFFF.
- `bitCount`  out  $clog2(WORD_W+1)  bits held in the current partial word.
- `fillLevel`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

## Operation
- Edge detect: the block registers `samplePulse` into `pulseQ` every cycle, independent of `enable`. `strobe = samplePulse & ~pulseQ & enable & ~clear`.
  - Raising `enable` while `samplePulse` is already high does not generate a strobe.
- Shift, per channel, on `strobe`:
  - MSB_FIRST=0: `sh <= {dIn[c], sh[WORD_W-1:1]}`.
  - MSB_FIRST=1: `sh <= {sh[WORD_W-2:0], dIn[c]}`.
- Bit counter: `bitCount` increments on each strobe.
  - On the strobe taken at `bitCount == WORD_W-1`, the assembled vector, including the current bit, is pushed and `bitCount` returns to 0.
  - No extra cycle is spent between words.
- FIFO:
  - push = word complete; pop = `outValid & outReady`.
  - Push to a full FIFO without a same-cycle pop drops the word, sets `overflow`, and increments `dropCount` with saturation.
  - Push and pop in the same cycle with the FIFO full: the push is accepted and `fillLevel` is unchanged.
  - Push and pop in the same cycle with the FIFO empty is impossible, because `outValid` is 0.
  - `outData` is held stable while `outValid=1` and no pop occurs.
- `enable` low: the partial word and `bitCount` are held; the FIFO still drains.
- `clear` (synchronous, highest priority after reset):
  - shift registers, `bitCount`, FIFO pointers, `overflow`, and `dropCount` go to 0.
  - `pulseQ` still updates.
  - A strobe or push in the same cycle is discarded.
- Reset (async, `resetN`=0): every register goes to 0 immediately, including mid-word or mid-transfer. The partial word is lost.

## Timing
- Reset values: `outData`=0, `outValid`=0, `overflow`=0, `dropCount`=0, `bitCount`=0, `fillLevel`=0.
- `dIn` is sampled in the cycle where `samplePulse` is high and `pulseQ` is low. `bitCount` updates at the end of that cycle.
- Capture latency: `outValid` rises 1 cycle after the completing strobe cycle when the FIFO was empty. `outData` is valid in that same cycle.
- Pop takes effect at the clock edge ending the handshake cycle. The next entry, or `outValid`=0, appears the following cycle.
- `overflow` and `dropCount` update 1 cycle after the dropping strobe.
- Minimum strobe spacing is 2 cycles, since the pulse must go low between strobes. Sustained throughput is 1 word per WORD_W strobes.

## Test plan
- LSB-first word:
  - Setup: CHANNELS=1, WORD_W=32. Drive 32 pulses carrying bits of 0xA5A50F0F, bit 0 first.
  - Required: `outData`=0xA5A50F0F, `outValid`=1 one cycle after the 32nd strobe, `bitCount`=0.
- MSB-first, multi-channel:
  - Setup: MSB_FIRST=1, CHANNELS=2, WORD_W=8. Ch0 sends 0x3C and ch1 sends 0xC3, MSB first.
  - Required: `outData`=0xC33C.
- Backpressure and overflow:
  - Setup: FIFO_DEPTH=4, `outReady`=0. Complete 5 words.
  - Required: `fillLevel`=4, `overflow`=1, `dropCount`=1. Draining then returns words 1–4 in order, and `overflow` stays 1.
- Full with simultaneous pop:
  - Setup: FIFO full. Assert `outReady` in the exact completing-strobe cycle.
  - Required: no drop, `fillLevel` stays 4, and the new word appears last.
- Enable gating:
  - Stimulus: deassert `enable` after 10 strobes, pulse 5 times, re-enable while `samplePulse` is high, then 22 more strobes.
  - Required: exactly one word, built from 32 enabled bits. The held-high pulse at re-enable is not counted.
- Reset and clear mid-word:
  - Stimulus: assert `resetN`=0 with `bitCount`=17 and 2 words queued.
  - Required: all outputs are 0 immediately. The same sequence using `clear` gives 0 on the next cycle, and the next 32 strobes form a clean word.
